// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: single-beat AXI4 read/write channels between the LSU master and the SRAM subordinate
interface axi_sram_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid
  );
  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI4 subordinate in front of a word-organised SRAM with programmable latency
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input logic      clk,
  input logic      rst,
  axi_sram_if.slave s_io
);
  typedef enum logic [2:0] {IDLE, RWAIT, RRESP, WWAIT, WRESP} state_t;
  localparam logic [32:0] SPAN     = 33'(4) << DEPTH_LOG2;
  localparam bit          NO_WAIT  = LATENCY == 0;
  localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(LATENCY - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q;
  logic prio_rd_q;
  logic ar_full_q, aw_full_q, w_full_q;
  logic [31:0] ar_addr_q, aw_addr_q, w_data_q, op_addr_q, op_data_q;
  logic [3:0] ar_id_q, aw_id_q, op_id_q, w_strb_q, op_strb_q;
  logic ar_len_q, aw_len_q, op_len_q;
  logic [31:0] rdata_q;
  logic [1:0] rresp_q, bresp_q;
  logic [3:0] rid_q, bid_q;
  logic [31:0] mem [1<<DEPTH_LOG2];
  logic ar_hs, aw_hs, w_hs, idle, rd_req, wr_req, gnt_rd, gnt_wr;
  logic acc, acc_wr, acc_ok, acc_len;
  logic [31:0] acc_addr, acc_off, acc_data;
  logic [3:0] acc_id, acc_strb;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic unused;
  assign unused = ^{s_io.awsize, s_io.arsize, s_io.awburst, s_io.arburst, s_io.wlast};
  assign s_io.arready = ~ar_full_q & ~rst;
  assign s_io.awready = ~aw_full_q & ~rst;
  assign s_io.wready  = ~w_full_q & ~rst;
  assign ar_hs = s_io.arvalid & s_io.arready;
  assign aw_hs = s_io.awvalid & s_io.awready;
  assign w_hs  = s_io.wvalid & s_io.wready;
  assign idle   = state_q == IDLE;
  assign rd_req = idle & ar_full_q;
  assign wr_req = idle & aw_full_q & w_full_q;
  assign gnt_rd = rd_req & (~wr_req | prio_rd_q);
  assign gnt_wr = wr_req & ~gnt_rd;
  // In IDLE the access operands come straight from the granted buffer so a zero latency needs no extra cycle
  assign acc      = idle ? (gnt_rd | gnt_wr) & NO_WAIT : (state_q == RWAIT || state_q == WWAIT) && cnt_q == '0;
  assign acc_wr   = idle ? gnt_wr : state_q == WWAIT;
  assign acc_addr = idle ? (gnt_rd ? ar_addr_q : aw_addr_q) : op_addr_q;
  assign acc_len  = idle ? (gnt_rd ? ar_len_q : aw_len_q) : op_len_q;
  assign acc_id   = idle ? (gnt_rd ? ar_id_q : aw_id_q) : op_id_q;
  assign acc_data = idle ? w_data_q : op_data_q;
  assign acc_strb = idle ? w_strb_q : op_strb_q;
  assign acc_off  = acc_addr - BASE_ADDR;
  assign acc_idx  = acc_off[DEPTH_LOG2+1:2];
  assign acc_ok   = {1'b0, acc_off} < SPAN && !acc_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = gnt_rd ? (NO_WAIT ? RRESP : RWAIT) : gnt_wr ? (NO_WAIT ? WRESP : WWAIT) : IDLE;
      RWAIT: state_d = cnt_q == '0 ? RRESP : RWAIT;
      WWAIT: state_d = cnt_q == '0 ? WRESP : WWAIT;
      RRESP: state_d = s_io.rready ? IDLE : RRESP;
      WRESP: state_d = s_io.bready ? IDLE : WRESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s_io.rvalid = state_q == RRESP;
    s_io.rlast  = state_q == RRESP;
    s_io.bvalid = state_q == WRESP;
  end
  assign s_io.rdata = rdata_q;
  assign s_io.rresp = rresp_q;
  assign s_io.rid   = rid_q;
  assign s_io.bresp = bresp_q;
  assign s_io.bid   = bid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ar_full_q <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      cnt_q     <= '0;
      prio_rd_q <= 1'b1;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      ar_full_q <= ar_hs | (ar_full_q & ~gnt_rd);
      aw_full_q <= aw_hs | (aw_full_q & ~gnt_wr);
      w_full_q  <= w_hs | (w_full_q & ~gnt_wr);
      cnt_q     <= (gnt_rd | gnt_wr) ? CNT_INIT : cnt_q != '0 ? cnt_q - 4'd1 : cnt_q;
      if (rd_req & wr_req) prio_rd_q <= ~prio_rd_q;
      if (acc & ~acc_wr) begin
        rdata_q <= acc_ok ? mem[acc_idx] : '0;
        rresp_q <= acc_ok ? 2'b00 : 2'b10;
        rid_q   <= acc_id;
      end
      if (acc & acc_wr) begin
        bresp_q <= acc_ok ? 2'b00 : 2'b10;
        bid_q   <= acc_id;
      end
    end
  always_ff @(posedge clk) begin
    if (ar_hs) {ar_addr_q, ar_id_q, ar_len_q} <= {s_io.araddr, s_io.arid, |s_io.arlen};
    if (aw_hs) {aw_addr_q, aw_id_q, aw_len_q} <= {s_io.awaddr, s_io.awid, |s_io.awlen};
    if (w_hs) {w_data_q, w_strb_q} <= {s_io.wdata, s_io.wstrb};
    if (gnt_rd | gnt_wr) {op_addr_q, op_len_q, op_id_q, op_data_q, op_strb_q} <= {acc_addr, acc_len, acc_id, acc_data, acc_strb};
  end
  // Memory is deliberately outside the reset domain so its contents survive rst
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (acc & acc_wr & acc_ok & acc_strb[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed plus randomized transactions checked against a word-array model of the SRAM
module tb_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DL = 12;
  localparam int LAT = 2;
  logic clk = 0, rst = 1;
  int cyc = 0, checks = 0, failures = 0;
  int h, at;
  bit is_r;
  logic [31:0] ed, a2;
  logic [31:0] ref_mem [int];
  axi_sram_if s();
  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .s_io(s));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a, input logic [7:0] len);
    logic [31:0] off;
    off = a - BASE;
    return off < (32'd4 << DL) && len == 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [7:0] len);
    if (!in_range(a, len)) return 32'h0;
    return ref_mem[widx(a)];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [7:0] len, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w;
    if (!in_range(a, len)) return;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[widx(a)] = w;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    s.araddr = a; s.arid = id; s.arlen = len;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    s.awaddr = a; s.awid = id; s.awlen = len;
  endtask

  task automatic set_w(input logic [31:0] d, input logic [3:0] strb);
    s.wdata = d; s.wstrb = strb;
  endtask

  // Presents the selected request channels and returns the cycle count after the last handshake edge
  task automatic present(input bit ar, input bit aw, input bit w, output int hs_cyc);
    int n;
    bit ha, hw, hd;
    s.arvalid = ar; s.awvalid = aw; s.wvalid = w;
    n = 0;
    hs_cyc = 0;
    while ((s.arvalid || s.awvalid || s.wvalid) && n < 20) begin
      ha = s.arvalid && s.arready;
      hw = s.awvalid && s.awready;
      hd = s.wvalid && s.wready;
      @(posedge clk);
      @(negedge clk);
      if (ha) s.arvalid = 0;
      if (hw) s.awvalid = 0;
      if (hd) s.wvalid = 0;
      if (ha || hw || hd) hs_cyc = cyc;
      n++;
    end
    chk("handshake_pending", {29'h0, s.arvalid, s.awvalid, s.wvalid}, 32'h0);
    s.arvalid = 0; s.awvalid = 0; s.wvalid = 0;
  endtask

  task automatic wait_resp(output bit r, output int t);
    int n;
    n = 0;
    while (!s.rvalid && !s.bvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", n < 100, 1);
    r = s.rvalid;
    t = cyc;
  endtask

  task automatic check_r(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id);
    chk("rvalid", s.rvalid, 1);
    chk("rdata", s.rdata, d);
    chk("rresp", s.rresp, resp);
    chk("rlast", s.rlast, 1);
    chk("rid", s.rid, id);
  endtask

  task automatic check_b(input logic [1:0] resp, input logic [3:0] id);
    chk("bvalid", s.bvalid, 1);
    chk("bresp", s.bresp, resp);
    chk("bid", s.bid, id);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int hc, t;
    bit r;
    set_ar(a, id, len);
    present(1, 0, 0, hc);
    wait_resp(r, t);
    chk("rd_is_read", r, 1);
    chk("rd_latency", t, hc - 1 + 2 + LAT);
    check_r(exp_rdata(a, len), in_range(a, len) ? 2'b00 : 2'b10, id);
    @(negedge clk);
    chk("rvalid_drop", s.rvalid, 0);
  endtask

  // gap>0: W leads AW by gap cycles; gap<0: AW leads W; gap==0: same cycle
  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] d, input logic [3:0] strb, input int gap);
    int hc, t;
    bit r;
    set_aw(a, id, len);
    set_w(d, strb);
    if (gap == 0) present(0, 1, 1, hc);
    else if (gap > 0) begin
      present(0, 0, 1, hc);
      repeat (gap - 1) @(negedge clk);
      present(0, 1, 0, hc);
    end else begin
      present(0, 1, 0, hc);
      repeat (-gap - 1) @(negedge clk);
      present(0, 0, 1, hc);
    end
    model_write(a, len, d, strb);
    wait_resp(r, t);
    chk("wr_is_write", r, 0);
    chk("wr_latency", t, hc - 1 + 2 + LAT);
    check_b(in_range(a, len) ? 2'b00 : 2'b10, id);
    @(negedge clk);
    chk("bvalid_drop", s.bvalid, 0);
  endtask

  initial begin
    s.arvalid = 0; s.awvalid = 0; s.wvalid = 0; s.rready = 1; s.bready = 1; s.wlast = 1;
    s.awsize = 3'd2; s.arsize = 3'd2; s.awburst = 2'd1; s.arburst = 2'd1;
    set_ar(BASE, 0, 0); set_aw(BASE, 0, 0); set_w(0, 0);
    repeat (3) @(negedge clk);
    chk("rst_arready", s.arready, 0);
    chk("rst_awready", s.awready, 0);
    chk("rst_wready", s.wready, 0);
    chk("rst_rvalid", s.rvalid, 0);
    chk("rst_bvalid", s.bvalid, 0);
    chk("rst_rdata", s.rdata, 0);
    chk("rst_rid_bid", {s.rid, s.bid, s.rresp, s.bresp, 3'b0, s.rlast}, 0);
    rst = 0;
    @(negedge clk);
    chk("arready_after_rst", s.arready, 1);
    // collision right after reset: read wins
    set_ar(32'h7FFF_FFFC, 2, 0); set_aw(BASE + 32'h10, 3, 0); set_w(32'hDEADBEEF, 4'hF);
    present(1, 1, 1, h);
    model_write(BASE + 32'h10, 0, 32'hDEADBEEF, 4'hF);
    wait_resp(is_r, at);
    chk("col1_read_first", is_r, 1);
    check_r(32'h0, 2'b10, 2);
    @(negedge clk);
    wait_resp(is_r, at);
    chk("col1_write_second", is_r, 0);
    check_b(2'b00, 3);
    @(negedge clk);
    do_read(BASE + 32'h10, 7, 0);
    // second collision: write wins, read sees written data
    set_aw(BASE + 32'h10, 4, 0); set_w(32'h11223344, 4'hF); set_ar(BASE + 32'h10, 6, 0);
    present(1, 1, 1, h);
    model_write(BASE + 32'h10, 0, 32'h11223344, 4'hF);
    wait_resp(is_r, at);
    chk("col2_write_first", is_r, 0);
    check_b(2'b00, 4);
    @(negedge clk);
    wait_resp(is_r, at);
    chk("col2_read_second", is_r, 1);
    check_r(exp_rdata(BASE + 32'h10, 0), 2'b00, 6);
    @(negedge clk);
    do_write(BASE + 32'h12, 1, 0, 32'h00AB0000, 4'b0100, 0);
    do_read(BASE + 32'h10, 1, 0);
    do_write(BASE + 32'h20, 5, 0, $urandom, 4'hF, 3);
    do_write(BASE + 32'h24, 5, 0, $urandom, 4'hF, -3);
    do_write(BASE + 32'h28, 5, 0, $urandom, 4'hF, 0);
    for (int i = 0; i < 16; i++) do_write(BASE + 32'h100 + 4 * i, 4'($urandom), 0, $urandom, 4'hF, 0);
    // response stall with a second read queued behind it
    s.rready = 0;
    set_ar(BASE + 32'h100, 8, 0);
    present(1, 0, 0, h);
    wait_resp(is_r, at);
    ed = exp_rdata(BASE + 32'h100, 0);
    check_r(ed, 2'b00, 8);
    chk("ar2_ready", s.arready, 1);
    set_ar(BASE + 32'h104, 9, 0);
    present(1, 0, 0, h);
    for (int i = 0; i < 4; i++) begin
      check_r(ed, 2'b00, 8);
      chk("ar_blocked", s.arready, 0);
      @(negedge clk);
    end
    s.rready = 1;
    @(negedge clk);
    wait_resp(is_r, at);
    chk("stall_second_read", is_r, 1);
    check_r(exp_rdata(BASE + 32'h104, 0), 2'b00, 9);
    @(negedge clk);
    // error responses leave memory untouched
    do_read(32'h7FFF_FFFC, 1, 0);
    do_read(BASE + (32'd4 << DL), 2, 0);
    do_read(BASE + 32'h10, 3, 1);
    do_write(BASE + (32'd4 << DL), 4, 0, $urandom, 4'hF, 0);
    do_write(BASE + 32'h10, 5, 1, $urandom, 4'hF, 0);
    do_write(32'h7FFF_FFFC, 6, 0, $urandom, 4'hF, 0);
    do_read(BASE + 32'h10, 6, 0);
    for (int i = 0; i < 24; i++) begin
      a2 = BASE + 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        do_write(a2, 4'($urandom), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0, $urandom, 4'($urandom), $urandom_range(0, 6) - 3);
      else
        do_read(a2, 4'($urandom), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0);
    end
    // reset while the write is waiting out its latency
    set_aw(BASE + 32'h10, 9, 0); set_w(32'hCAFEF00D, 4'hF);
    present(0, 1, 1, h);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_wwait_bvalid", s.bvalid, 0);
    chk("rst_wwait_awready", s.awready, 0);
    rst = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("post_rst_bvalid", s.bvalid, 0);
    end
    do_read(BASE + 32'h10, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
